i2s_target_tx: RTL and testbench
================================

Name: i2s_target_tx

Overview:
- I2S target (slave) transmitter: the opposite end of our I2S master links.
- The external master drives SCK and WS; this block follows them and shifts stereo samples out on SD, MSB first, in standard I2S format (one-SCK MSB delay).
- It lets the FPGA act as the audio source for an external master (DSP or codec in master mode).
- Samples arrive on a valid/ready handshake into a one-pair holding buffer, so the EQ output can feed it directly.

Parameters:
- DATA_WIDTH, 24: bits per channel word shifted out; range 8..32.
- CNT_WIDTH, 16: width of the saturating underrun counter.

Ports:
- lmmi_clk_i  input  1  system clock; must be at least 8x the SCK frequency.
- reset_n_i  input  1  asynchronous active-low reset.
- conf_en_i  input  1  transmitter enable.
- i2s_sck_i  input  1  bit clock from the external master; asynchronous to lmmi_clk_i.
- i2s_ws_i  input  1  word select from the master; 0 = left, 1 = right.
- i2s_sd_o  output  1  serial data to the master.
- sample_l_i  input  DATA_WIDTH  left sample, two's complement.
- sample_r_i  input  DATA_WIDTH  right sample, two's complement.
- sample_valid_i  input  1  sample pair valid.
- sample_ready_o  output  1  holding buffer empty; the pair is accepted when valid && ready.
- underrun_o  output  1  one-cycle pulse: a left word started while the buffer was empty.
- underrun_cnt_o  output  CNT_WIDTH  saturating underrun count.
- aligned_o  output  1  high once frame alignment is achieved.

Behaviour:
- Reset values: i2s_sd_o=0, sample_ready_o=0, underrun_o=0, underrun_cnt_o=0, aligned_o=0. The buffer, shifters, bit counter, synchronisers and FSM all clear.
- Synchronisation:
  - SCK and WS each pass through a 2-FF synchroniser plus one history register.
  - Rise/fall strobes are asserted on the cycle the synchronised value differs from history.
- WS is captured on each SCK rise strobe.
- A word start is a WS capture that differs from the previous capture. WS 1->0 starts a left word; WS 0->1 starts a right word.
- i2s_sd_o is registered and updates only on SCK fall strobes, 3 lmmi_clk_i cycles after the pin edge (4 if the synchroniser resolves late).
- FSM states:
  - IDLE: sd=0; sample_ready_o=0 while conf_en_i=0, else equal to buffer-empty. Moves to LEFT on the first left-word start while conf_en_i=1. Never starts mid-frame.
  - LEFT / RIGHT: move on a word start of the respective channel.
  - Any state goes to IDLE within one cycle of conf_en_i=0. In that case: shifters are cleared, sd=0, the buffer is kept, aligned_o=0.
- aligned_o=1 in LEFT and RIGHT.
- Left-word start:
  - If the buffer is full: copy the pair into the L and R shifters and mark the buffer empty.
  - Otherwise: underrun. Load zeros into both shifters, pulse underrun_o, and increment underrun_cnt_o (saturating at all-ones).
  - A handshake in the same cycle as an empty-buffer left start is still an underrun. The accepted pair waits for the next frame.
- Right-word start: select the R shifter (already loaded).
- Shifting:
  - On the first SCK fall after a word start, drive the MSB.
  - On each following fall, drive the next bit.
  - After DATA_WIDTH bits, drive 0 until the next word start (slot longer than word).
  - A word start arriving before all bits are sent truncates the word; the new word starts normally (slot shorter than word).
- Handshake:
  - sample_ready_o = conf_en_i && buffer empty; combinational from registered state.
  - Capture happens on valid && ready; the buffer becomes full the next cycle.
  - Data must be held while valid=1 && ready=0.
- Reset asserted mid-word: all outputs return to reset values immediately. After release the block realigns from IDLE.

Optional Feature:
- I2S_TX_UNDERRUN_REPEAT_EN.
- Defined: on underrun, the shifters reload the last successfully transmitted pair (zeros if none since reset). underrun_o and the counter behave as before.
- Undefined: underrun transmits zeros.

Test Plan:
1. Alignment: bench master at SCK=lmmi/8, 32-bit slots. Enable mid-right-slot with pair L=24'hA5_0F3C, R=24'h81_2345 presented. Required: sd=0 until the first WS 1->0; left slot then carries A50F3C MSB-first starting one SCK after the WS edge; 8 trailing zeros; right slot carries 812345; aligned_o rises.
2. Streaming: supply 4 consecutive pairs (L=n, R=~n), each presented when ready. Required: the master receiver decodes all 4 in order; underrun_cnt_o stays 0; ready drops for exactly one cycle-plus per accept.
3. Underrun: withhold valid for 2 frames. Required: two underrun_o pulses, underrun_cnt_o=2, and both slots zero in each starved frame. With the macro defined, the last pair repeats instead.
4. Short slots: 16-bit slots with DATA_WIDTH=24, L=24'hFFFFFF. Required: 16 ones are transmitted and the next word starts cleanly at its MSB with no leftover bits.
5. Disable/reset mid-word: drop conf_en_i during left bit 10. Required: sd=0 within 4 lmmi cycles, aligned_o=0, and realignment at the next WS falling edge. Repeat with reset_n_i low: underrun_cnt_o=0 and sample_ready_o=0 immediately.
6. Counter saturation: with CNT_WIDTH=4, force 20 underruns. Required: underrun_cnt_o holds at 4'hF.

Source files
------------

// File: rtl/i2s_target_tx.sv
// I2S target transmitter: follows an external SCK/WS pair and shifts stereo samples out MSB-first.
// Optional build macro I2S_TX_UNDERRUN_REPEAT_EN: on underrun, resend the last loaded pair instead of zeros.
module i2s_target_tx #(
  parameter int DATA_WIDTH = 24,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  lmmi_clk_i,
  input  logic                  reset_n_i,
  input  logic                  conf_en_i,
  input  logic                  i2s_sck_i,
  input  logic                  i2s_ws_i,
  output logic                  i2s_sd_o,
  input  logic [DATA_WIDTH-1:0] sample_l_i,
  input  logic [DATA_WIDTH-1:0] sample_r_i,
  input  logic                  sample_valid_i,
  output logic                  sample_ready_o,
  output logic                  underrun_o,
  output logic [CNT_WIDTH-1:0]  underrun_cnt_o,
  output logic                  aligned_o
);

  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [BW-1:0] BITS_L = BW'(DATA_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEFT  = 2'd1,
    ST_RIGHT = 2'd2
  } state_t;

  logic                  sck_meta_q, sck_sync_q, sck_hist_q;
  logic                  ws_meta_q, ws_sync_q, ws_hist_q;
  logic                  ws_cap_q, ws_cap_d;
  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] buf_l_q, buf_l_d, buf_r_q, buf_r_d;
  logic                  buf_full_q, buf_full_d;
  logic [DATA_WIDTH-1:0] sh_l_q, sh_l_d, sh_r_q, sh_r_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic                  sd_q, sd_d;
  logic                  underrun_q, underrun_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  run_q;
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
  logic [DATA_WIDTH-1:0] last_l_q, last_l_d, last_r_q, last_r_d;
`endif

  logic sck_rise_s, sck_fall_s, ws_start_s, left_start_s, right_start_s;
  logic ready_s, accept_s;

  assign sck_rise_s    = sck_sync_q & ~sck_hist_q;
  assign sck_fall_s    = ~sck_sync_q & sck_hist_q;
  // WS history is time-aligned with the SCK history, i.e. WS as it was when SCK rose.
  assign ws_start_s    = sck_rise_s & (ws_hist_q != ws_cap_q);
  assign left_start_s  = ws_start_s & ~ws_hist_q;
  assign right_start_s = ws_start_s & ws_hist_q;

  // run_q keeps ready low while reset is asserted even if the enable is high.
  assign ready_s  = conf_en_i & run_q & ~buf_full_q;
  assign accept_s = sample_valid_i & ready_s;

  assign sample_ready_o = ready_s;
  assign i2s_sd_o       = sd_q;
  assign underrun_o     = underrun_q;
  assign underrun_cnt_o = cnt_q;
  assign aligned_o      = (state_q != ST_IDLE);

  // Next-state, buffer, shifter and serial-data computation.
  always_comb begin
    ws_cap_d   = ws_cap_q;
    state_d    = state_q;
    buf_l_d    = buf_l_q;
    buf_r_d    = buf_r_q;
    buf_full_d = buf_full_q;
    sh_l_d     = sh_l_q;
    sh_r_d     = sh_r_q;
    bit_cnt_d  = bit_cnt_q;
    sd_d       = sd_q;
    underrun_d = 1'b0;
    cnt_d      = cnt_q;
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
    last_l_d   = last_l_q;
    last_r_d   = last_r_q;
`endif

    if (sck_rise_s) begin
      ws_cap_d = ws_hist_q;
    end else begin
      ws_cap_d = ws_cap_q;
    end

    if (accept_s) begin
      buf_l_d    = sample_l_i;
      buf_r_d    = sample_r_i;
      buf_full_d = 1'b1;
    end else begin
      buf_full_d = buf_full_q;
    end

    if (!conf_en_i) begin
      state_d   = ST_IDLE;
      sh_l_d    = '0;
      sh_r_d    = '0;
      bit_cnt_d = '0;
      sd_d      = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          sd_d = 1'b0;
          if (left_start_s) state_d = ST_LEFT;
          else              state_d = ST_IDLE;
        end
        ST_LEFT: begin
          if (right_start_s) state_d = ST_RIGHT;
          else               state_d = ST_LEFT;
        end
        ST_RIGHT: begin
          if (left_start_s) state_d = ST_LEFT;
          else              state_d = ST_RIGHT;
        end
        default: state_d = ST_IDLE;
      endcase

      if (left_start_s) begin
        bit_cnt_d = '0;
        if (buf_full_q) begin
          sh_l_d     = buf_l_q;
          sh_r_d     = buf_r_q;
          buf_full_d = 1'b0;
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
          last_l_d   = buf_l_q;
          last_r_d   = buf_r_q;
`endif
        end else begin
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
          sh_l_d = last_l_q;
          sh_r_d = last_r_q;
`else
          sh_l_d = '0;
          sh_r_d = '0;
`endif
          underrun_d = 1'b1;
          if (cnt_q != {CNT_WIDTH{1'b1}}) cnt_d = cnt_q + CNT_WIDTH'(1);
          else                            cnt_d = cnt_q;
        end
      end else if (right_start_s && (state_q == ST_LEFT)) begin
        bit_cnt_d = '0;
      end else if (sck_fall_s && (state_q != ST_IDLE)) begin
        // Past the word length the shifter is exhausted; pad the slot with zeros.
        if (bit_cnt_q < BITS_L) begin
          bit_cnt_d = bit_cnt_q + BW'(1);
          if (state_q == ST_LEFT) begin
            sd_d   = sh_l_q[DATA_WIDTH-1];
            sh_l_d = {sh_l_q[DATA_WIDTH-2:0], 1'b0};
          end else begin
            sd_d   = sh_r_q[DATA_WIDTH-1];
            sh_r_d = {sh_r_q[DATA_WIDTH-2:0], 1'b0};
          end
        end else begin
          sd_d = 1'b0;
        end
      end else begin
        bit_cnt_d = bit_cnt_q;
      end
    end
  end

  // Synchronisers and all state registers.
  always_ff @(posedge lmmi_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sck_meta_q <= 1'b0;
      sck_sync_q <= 1'b0;
      sck_hist_q <= 1'b0;
      ws_meta_q  <= 1'b0;
      ws_sync_q  <= 1'b0;
      ws_hist_q  <= 1'b0;
      ws_cap_q   <= 1'b0;
      state_q    <= ST_IDLE;
      buf_l_q    <= '0;
      buf_r_q    <= '0;
      buf_full_q <= 1'b0;
      sh_l_q     <= '0;
      sh_r_q     <= '0;
      bit_cnt_q  <= '0;
      sd_q       <= 1'b0;
      underrun_q <= 1'b0;
      cnt_q      <= '0;
      run_q      <= 1'b0;
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
      last_l_q   <= '0;
      last_r_q   <= '0;
`endif
    end else begin
      sck_meta_q <= i2s_sck_i;
      sck_sync_q <= sck_meta_q;
      sck_hist_q <= sck_sync_q;
      ws_meta_q  <= i2s_ws_i;
      ws_sync_q  <= ws_meta_q;
      ws_hist_q  <= ws_sync_q;
      ws_cap_q   <= ws_cap_d;
      state_q    <= state_d;
      buf_l_q    <= buf_l_d;
      buf_r_q    <= buf_r_d;
      buf_full_q <= buf_full_d;
      sh_l_q     <= sh_l_d;
      sh_r_q     <= sh_r_d;
      bit_cnt_q  <= bit_cnt_d;
      sd_q       <= sd_d;
      underrun_q <= underrun_d;
      cnt_q      <= cnt_d;
      run_q      <= 1'b1;
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
      last_l_q   <= last_l_d;
      last_r_q   <= last_r_d;
`endif
    end
  end

endmodule

// File: tb/tb_i2s_target_tx.sv
// Directed bench for i2s_target_tx: a bench-side I2S master drives SCK/WS and decodes SD.
module tb_i2s_target_tx;
  localparam int DW = 24;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          sck = 1'b1;
  logic          ws = 1'b0;
  logic          sd;
  logic [DW-1:0] sl = '0;
  logic [DW-1:0] sr = '0;
  logic          valid = 1'b0;
  logic          ready;
  logic          underrun;
  logic [CW-1:0] cnt;
  logic          aligned;

  int n_vec = 0;
  int n_err = 0;
  int feed_n = 0;
  int feed_ptr = 0;
  int ur_pulses = 0;
  logic [DW-1:0] fl [0:63];
  logic [DW-1:0] fr [0:63];
  logic [31:0]   hist = '0;
  logic [31:0]   lw, rw;

  i2s_target_tx #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .lmmi_clk_i(clk), .reset_n_i(rst_n), .conf_en_i(en),
    .i2s_sck_i(sck), .i2s_ws_i(ws), .i2s_sd_o(sd),
    .sample_l_i(sl), .sample_r_i(sr), .sample_valid_i(valid),
    .sample_ready_o(ready), .underrun_o(underrun),
    .underrun_cnt_o(cnt), .aligned_o(aligned)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (valid && ready) feed_ptr <= feed_ptr + 1;
    if (underrun) ur_pulses <= ur_pulses + 1;
  end

  initial begin
    forever begin
      @(negedge clk);
      if (feed_ptr < feed_n) begin
        sl = fl[feed_ptr];
        sr = fr[feed_ptr];
        valid = 1'b1;
      end else begin
        valid = 1'b0;
      end
    end
  end

  task automatic push(input logic [DW-1:0] l, input logic [DW-1:0] r);
    fl[feed_n] = l;
    fr[feed_n] = r;
    feed_n++;
  endtask

  function automatic logic [31:0] mask(input int n);
    logic [63:0] m;
    m = (64'd1 << n) - 64'd1;
    return m[31:0];
  endfunction

  // One SCK period: WS changes on the fall, SD is sampled at the rise.
  task automatic cyc(input logic w);
    sck = 1'b0;
    ws = w;
    #40;
    hist = {hist[30:0], sd};
    sck = 1'b1;
    #40;
  endtask

  task automatic frame(input int n, output logic [31:0] l_o, output logic [31:0] r_o);
    l_o = '0;
    for (int i = 0; i < n; i++) cyc(1'b0);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1);
      if (i == 0) l_o = hist & mask(n);
    end
    r_o = hist & mask(n - 1);
  endtask

  task automatic test_reset();
    en = 1'b1;
    #40;
    n_vec++; if (sd !== 1'b0) begin n_err++; $display("FAIL reset_sd got %b want 0", sd); end
    n_vec++; if (ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got %b want 0", ready); end
    n_vec++; if (underrun !== 1'b0) begin n_err++; $display("FAIL reset_underrun got %b want 0", underrun); end
    n_vec++; if (cnt !== 4'h0) begin n_err++; $display("FAIL reset_cnt got %h want 0", cnt); end
    n_vec++; if (aligned !== 1'b0) begin n_err++; $display("FAIL reset_aligned got %b want 0", aligned); end
    en = 1'b0;
    rst_n = 1'b1;
    #80;
  endtask

  task automatic test_alignment();
    frame(32, lw, rw);
    n_vec++; if ((lw | rw) !== 32'h0) begin n_err++; $display("FAIL align_disabled_sd got %h/%h want 0", lw, rw); end
    n_vec++; if (ready !== 1'b0) begin n_err++; $display("FAIL align_ready_disabled got %b want 0", ready); end
    for (int i = 0; i < 32; i++) cyc(1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b1);
    en = 1'b1;
    push(24'hA50F3C, 24'h812345);
    #80;
    n_vec++; if (ready !== 1'b0) begin n_err++; $display("FAIL align_ready_after_accept got %b want 0", ready); end
    n_vec++; if (aligned !== 1'b0) begin n_err++; $display("FAIL align_early got %b want 0", aligned); end
    for (int i = 0; i < 22; i++) cyc(1'b1);
    n_vec++; if ((hist & mask(22)) !== 32'h0) begin n_err++; $display("FAIL align_midframe_sd got %h want 0", hist & mask(22)); end
    frame(32, lw, rw);
    n_vec++; if (lw !== {24'hA50F3C, 8'h00}) begin n_err++; $display("FAIL align_left got %h want %h", lw, {24'hA50F3C, 8'h00}); end
    n_vec++; if (rw !== {1'b0, 24'h812345, 7'h00}) begin n_err++; $display("FAIL align_right got %h want %h", rw, {1'b0, 24'h812345, 7'h00}); end
    n_vec++; if (aligned !== 1'b1) begin n_err++; $display("FAIL align_aligned got %b want 1", aligned); end
  endtask

  task automatic test_streaming();
    logic [DW-1:0] l, r;
    for (int k = 1; k <= 4; k++) push(DW'(k), ~DW'(k));
    for (int k = 1; k <= 4; k++) begin
      l = DW'(k);
      r = ~DW'(k);
      frame(32, lw, rw);
      n_vec++; if (lw !== {l, 8'h00}) begin n_err++; $display("FAIL stream_left%0d got %h want %h", k, lw, {l, 8'h00}); end
      n_vec++; if (rw !== {1'b0, r, 7'h00}) begin n_err++; $display("FAIL stream_right%0d got %h want %h", k, rw, {1'b0, r, 7'h00}); end
    end
    n_vec++; if (cnt !== 4'h0) begin n_err++; $display("FAIL stream_cnt got %h want 0", cnt); end
    n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL stream_ready_empty got %b want 1", ready); end
  endtask

  task automatic test_underrun();
    int ur0;
    logic [31:0] el, er;
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
    el = {24'h000004, 8'h00};
    er = {1'b0, 24'hFFFFFB, 7'h00};
`else
    el = 32'h0;
    er = 32'h0;
`endif
    ur0 = ur_pulses;
    for (int k = 0; k < 2; k++) begin
      frame(32, lw, rw);
      n_vec++; if (lw !== el) begin n_err++; $display("FAIL underrun_left%0d got %h want %h", k, lw, el); end
      n_vec++; if (rw !== er) begin n_err++; $display("FAIL underrun_right%0d got %h want %h", k, rw, er); end
    end
    n_vec++; if (cnt !== 4'h2) begin n_err++; $display("FAIL underrun_cnt got %h want 2", cnt); end
    n_vec++; if (ur_pulses - ur0 !== 2) begin n_err++; $display("FAIL underrun_pulses got %0d want 2", ur_pulses - ur0); end
  endtask

  task automatic test_short_slots();
    push(24'hFFFFFF, 24'h123456);
    push(24'h800001, 24'hFEDCBA);
    frame(16, lw, rw);
    n_vec++; if (lw !== 32'h0000FFFF) begin n_err++; $display("FAIL short_left1 got %h want 0000ffff", lw); end
    n_vec++; if (rw !== 32'h0000091A) begin n_err++; $display("FAIL short_right1 got %h want 0000091a", rw); end
    frame(16, lw, rw);
    n_vec++; if (lw !== 32'h00008000) begin n_err++; $display("FAIL short_left2 got %h want 00008000", lw); end
    n_vec++; if (rw !== 32'h00007F6E) begin n_err++; $display("FAIL short_right2 got %h want 00007f6e", rw); end
    n_vec++; if (cnt !== 4'h2) begin n_err++; $display("FAIL short_cnt got %h want 2", cnt); end
  endtask

  task automatic test_disable_reset();
    push(24'hFFFFFF, 24'h000000);
    push(24'hABCDEF, 24'h135790);
    for (int i = 0; i < 11; i++) cyc(1'b0);
    n_vec++; if (sd !== 1'b1) begin n_err++; $display("FAIL dis_sd_before got %b want 1", sd); end
    en = 1'b0;
    #40;
    n_vec++; if (sd !== 1'b0) begin n_err++; $display("FAIL dis_sd got %b want 0", sd); end
    n_vec++; if (aligned !== 1'b0) begin n_err++; $display("FAIL dis_aligned got %b want 0", aligned); end
    for (int i = 0; i < 21; i++) cyc(1'b0);
    en = 1'b1;
    for (int i = 0; i < 32; i++) cyc(1'b1);
    n_vec++; if (hist !== 32'h0) begin n_err++; $display("FAIL dis_right_sd got %h want 0", hist); end
    n_vec++; if (aligned !== 1'b0) begin n_err++; $display("FAIL dis_no_early_align got %b want 1'b0", aligned); end
    frame(32, lw, rw);
    n_vec++; if (lw !== {24'hABCDEF, 8'h00}) begin n_err++; $display("FAIL dis_realign_left got %h want %h", lw, {24'hABCDEF, 8'h00}); end
    n_vec++; if (rw !== {1'b0, 24'h135790, 7'h00}) begin n_err++; $display("FAIL dis_realign_right got %h want %h", rw, {1'b0, 24'h135790, 7'h00}); end

    push(24'hFFFFFF, 24'hFFFFFF);
    for (int i = 0; i < 11; i++) cyc(1'b0);
    n_vec++; if (sd !== 1'b1) begin n_err++; $display("FAIL rst_sd_before got %b want 1", sd); end
    rst_n = 1'b0;
    #1;
    n_vec++; if (cnt !== 4'h0) begin n_err++; $display("FAIL rst_cnt got %h want 0", cnt); end
    n_vec++; if (ready !== 1'b0) begin n_err++; $display("FAIL rst_ready got %b want 0", ready); end
    n_vec++; if (sd !== 1'b0) begin n_err++; $display("FAIL rst_sd got %b want 0", sd); end
    n_vec++; if (aligned !== 1'b0) begin n_err++; $display("FAIL rst_aligned got %b want 0", aligned); end
    #39;
    rst_n = 1'b1;
    push(24'h5A5A5A, 24'hA5A5A5);
    for (int i = 0; i < 21; i++) cyc(1'b0);
    for (int i = 0; i < 32; i++) cyc(1'b1);
    n_vec++; if (hist !== 32'h0) begin n_err++; $display("FAIL rst_right_sd got %h want 0", hist); end
    frame(32, lw, rw);
    n_vec++; if (lw !== {24'h5A5A5A, 8'h00}) begin n_err++; $display("FAIL rst_realign_left got %h want %h", lw, {24'h5A5A5A, 8'h00}); end
    n_vec++; if (rw !== {1'b0, 24'hA5A5A5, 7'h00}) begin n_err++; $display("FAIL rst_realign_right got %h want %h", rw, {1'b0, 24'hA5A5A5, 7'h00}); end
    n_vec++; if (cnt !== 4'h0) begin n_err++; $display("FAIL rst_realign_cnt got %h want 0", cnt); end
  endtask

  task automatic test_saturation();
    int ur0;
    rst_n = 1'b0;
    #40;
    rst_n = 1'b1;
    ur0 = ur_pulses;
    // The first frame after reset has no WS 1->0 edge, so 21 frames give 20 left starts.
    for (int k = 0; k < 15; k++) frame(16, lw, rw);
    n_vec++; if (cnt !== 4'hE) begin n_err++; $display("FAIL sat_cnt14 got %h want e", cnt); end
    for (int k = 0; k < 6; k++) frame(16, lw, rw);
    n_vec++; if (cnt !== 4'hF) begin n_err++; $display("FAIL sat_cnt got %h want f", cnt); end
    n_vec++; if (ur_pulses - ur0 !== 20) begin n_err++; $display("FAIL sat_pulses got %0d want 20", ur_pulses - ur0); end
    n_vec++; if ((lw | rw) !== 32'h0) begin n_err++; $display("FAIL sat_zero_data got %h/%h want 0", lw, rw); end
  endtask

  initial begin
    #2;
    test_reset();
    test_alignment();
    test_streaming();
    test_underrun();
    test_short_slots();
    test_disable_reset();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
